module_scan_ctrl: RTL and testbench

MODULE_SCAN_CTRL -- requirements
Module: module_scan_ctrl

---
 rtl/module_scan_ctrl_if.sv | 15 +
 rtl/module_scan_ctrl.sv | 119 +++++++++++
 tb/tb_module_scan_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/module_scan_ctrl_if.sv
// Update handshake between a digit-pair sender and module_scan_ctrl.
//   upd_valid : sender offers a new digit pair
//   upd_d0    : value for digit 0
//   upd_d1    : value for digit 1
//   upd_ready : controller accepts the pair this cycle
// master = sender side, slave = controller side.
interface module_scan_ctrl_if;
   logic       upd_valid;
   logic [3:0] upd_d0;
   logic [3:0] upd_d1;
   logic       upd_ready;

   modport master (output upd_valid, output upd_d0, output upd_d1, input upd_ready);
   modport slave  (input upd_valid, input upd_d0, input upd_d1, output upd_ready);
endinterface

// File: rtl/module_scan_ctrl.sv
// Two-digit multiplexed 7-segment scan controller.
// Cycles BLANK0 -> DIG0 -> BLANK1 -> DIG1, with dead time between digits so the
// two BJT enables never overlap. Digit values are taken from shadow registers
// that only load during BLANK0, so a frame is never torn by a mid-frame update.
//
// Ports:
//   clk        : system clock, rising edge only
//   rst        : asynchronous active-high reset
//   upd        : update handshake (slave modport of module_scan_ctrl_if)
//   w          : nibble to the BCD/7-segment decoder (0 while blanked)
//   x          : digit-0 enable, active-high
//   y          : digit-1 enable, active-high
//   frame_tick : one-cycle pulse on the last cycle of DIG1
//
// Optional feature macro: SCAN_CTRL_ZERO_BLANK_EN
//   When defined, DIG1 with shadow d1 == 0 keeps y = 0 (leading-zero
//   suppression); timing and frame_tick are unaffected.
module module_scan_ctrl #(
   parameter int unsigned CLK_HZ    = 27000000,
   parameter int unsigned SCAN_HZ   = 1000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   module_scan_ctrl_if.slave   upd,
   output logic [3:0]          w,
   output logic                x,
   output logic                y,
   output logic                frame_tick
);

   localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
   localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CNT_W-1:0] DIG_LOAD   = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYC - 1);

   typedef enum logic [1:0] {StBlank0, StDig0, StBlank1, StDig1} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       sh_d0_q, sh_d0_d;
   logic [3:0]       sh_d1_q, sh_d1_d;
   logic             ready_q;
   logic             ready_d, x_d, y_d, tick_d;
   logic [3:0]       w_d;

   // State and dwell counter: count down, move on only once the count is 0.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_W'(1);
      end else begin
         unique case (state_q)
            StBlank0: begin state_d = StDig0;   cnt_d = DIG_LOAD;   end
            StDig0:   begin state_d = StBlank1; cnt_d = BLANK_LOAD; end
            StBlank1: begin state_d = StDig1;   cnt_d = DIG_LOAD;   end
            StDig1:   begin state_d = StBlank0; cnt_d = BLANK_LOAD; end
         endcase
      end
   end

   // Shadow capture; repeated transfers within one BLANK0 overwrite.
   always_comb begin
      sh_d0_d = sh_d0_q;
      sh_d1_d = sh_d1_q;
      if (upd.upd_valid && (state_q == StBlank0)) begin
         sh_d0_d = upd.upd_d0;
         sh_d1_d = upd.upd_d1;
      end
   end

   // Outputs are decoded from next state so the registered copies line up
   // with the state register cycle for cycle.
   always_comb begin
      ready_d = (state_d == StBlank0);
      x_d     = (state_d == StDig0);
`ifdef SCAN_CTRL_ZERO_BLANK_EN
      y_d     = (state_d == StDig1) && (sh_d1_d != 4'h0);
`else
      y_d     = (state_d == StDig1);
`endif
      tick_d  = (state_d == StDig1) && (cnt_d == '0);
      w_d     = 4'h0;
      if (state_d == StDig0) begin
         w_d = sh_d0_d;
      end else if (state_d == StDig1) begin
         w_d = sh_d1_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StBlank0;
         cnt_q      <= BLANK_LOAD;
         sh_d0_q    <= 4'h0;
         sh_d1_q    <= 4'h0;
         ready_q    <= 1'b1;
         x          <= 1'b0;
         y          <= 1'b0;
         w          <= 4'h0;
         frame_tick <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_d0_q    <= sh_d0_d;
         sh_d1_q    <= sh_d1_d;
         ready_q    <= ready_d;
         x          <= x_d;
         y          <= y_d;
         w          <= w_d;
         frame_tick <= tick_d;
      end
   end

   assign upd.upd_ready = ready_q;

endmodule

// File: tb/tb_module_scan_ctrl.sv
// Self-checking bench for module_scan_ctrl with DIV=10, BLANK_CYC=2 (24-cycle frame).
// A time-based model (cycle position within the frame plus shadow values)
// predicts every output on every falling edge; directed sections pin the
// model with hand-computed literal values.
module tb_module_scan_ctrl;

   localparam int DIV   = 10;
   localparam int BLANK = 2;
   localparam int FRAME = 2 * (DIV + BLANK);

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] w;
   logic       x, y, frame_tick;
   logic       run_chk = 1'b0;

   int n_vec = 0;
   int n_err = 0;

   module_scan_ctrl_if upd_if ();

   module_scan_ctrl #(
      .CLK_HZ   (1000),
      .SCAN_HZ  (100),
      .BLANK_CYC(BLANK)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .upd       (upd_if),
      .w         (w),
      .x         (x),
      .y         (y),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // Model: position within the frame since reset release, and shadow values.
   int         phase = 0;
   logic [3:0] m_d0 = 4'h0;
   logic [3:0] m_d1 = 4'h0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         phase <= 0;
         m_d0  <= 4'h0;
         m_d1  <= 4'h0;
      end else begin
         if (phase < BLANK && upd_if.upd_valid) begin
            m_d0 <= upd_if.upd_d0;
            m_d1 <= upd_if.upd_d1;
         end
         phase <= (phase + 1) % FRAME;
      end
   end

   // {upd_ready, x, y, frame_tick, w[3:0]}
   function automatic logic [7:0] exp_vec(input int p, input logic [3:0] d0,
                                          input logic [3:0] d1);
      logic       e_rdy, e_x, e_y, e_t;
      logic [3:0] e_w;
      e_rdy = (p < BLANK);
      e_x   = (p >= BLANK) && (p < BLANK + DIV);
      e_y   = (p >= 2 * BLANK + DIV);
`ifdef SCAN_CTRL_ZERO_BLANK_EN
      e_y   = e_y && (d1 != 4'h0);
`endif
      e_t   = (p == FRAME - 1);
      e_w   = e_x ? d0 : (e_y ? d1 : 4'h0);
      return {e_rdy, e_x, e_y, e_t, e_w};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (run_chk) begin
         chk("cycle_outputs", {24'h0, upd_if.upd_ready, x, y, frame_tick, w},
             {24'h0, exp_vec(phase, m_d0, m_d1)});
         chk("x_and_y", {31'h0, x & y}, 32'h0);
         chk("blank_w", {28'h0, (!x && !y) ? w : 4'h0}, 32'h0);
      end
   end

   // Advance whole cycles until the model is at frame position p.
   task automatic goto(input int p);
      int n = 0;
      while (phase != p && n < 60) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (phase != p) chk("goto_timeout", phase, p);
   endtask

   task automatic offer(input logic v, input logic [3:0] d0, input logic [3:0] d1);
      upd_if.upd_valid = v;
      upd_if.upd_d0    = d0;
      upd_if.upd_d1    = d1;
   endtask

   logic xs[30];
   logic ys[30];
   logic ts[30];

   initial begin
      int fx, fy, ft, nx, ny, nt;
      offer(1'b0, 4'h0, 4'h0);
      rst = 1'b1;
      @(posedge clk);
      run_chk = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;

      // Reset release, no updates: record the first 30 cycles.
      for (int i = 0; i < 30; i++) begin
         #1;
         xs[i] = x;
         ys[i] = y;
         ts[i] = frame_tick;
         @(posedge clk);
         #2;
      end
      fx = -1; fy = -1; ft = -1; nx = 0; ny = 0; nt = 0;
      for (int i = 0; i < FRAME; i++) begin
         if (xs[i] && fx < 0) fx = i;
         if (ys[i] && fy < 0) fy = i;
         if (ts[i] && ft < 0) ft = i;
         if (xs[i]) nx++;
         if (ys[i]) ny++;
         if (ts[i]) nt++;
      end
`ifndef SCAN_CTRL_ZERO_BLANK_EN
      chk("first_y", fy, 14);
      chk("y_len", ny, 10);
`else
      chk("y_suppressed", ny, 0);
`endif
      chk("first_x", fx, 2);
      chk("x_len", nx, 10);
      chk("tick_at", ft, 23);
      chk("tick_cnt", nt, 1);

      // Update held from mid-DIG1: captured only in BLANK0.
      goto(18);
      offer(1'b1, 4'h9, 4'h5);
      goto(20);
      #1 chk("no_early_capture", w, 4'h0);
      goto(2);
      offer(1'b0, 4'h0, 4'h0);
      #1 chk("dig0_w9", {x, w}, {1'b1, 4'h9});
      goto(14);
      #1 chk("dig1_w5", {y, w}, {1'b1, 4'h5});

      // Pulse during DIG0 is ignored.
      goto(4);
      offer(1'b1, 4'hF, 4'hE);
      @(posedge clk);
      #2;
      offer(1'b0, 4'h0, 4'h0);
      goto(8);
      #1 chk("ignored_d0", w, 4'h9);
      goto(16);
      #1 chk("ignored_d1", w, 4'h5);

      // Two transfers in one BLANK0: last wins.
      goto(0);
      offer(1'b1, 4'h3, 4'h1);
      @(posedge clk);
      #2;
      offer(1'b1, 4'h7, 4'h2);
      @(posedge clk);
      #2;
      offer(1'b0, 4'h0, 4'h0);
      #1 chk("last_wins_d0", w, 4'h7);
      goto(15);
      #1 chk("last_wins_d1", w, 4'h2);

      // Reset pulse mid-DIG1.
      goto(18);
      rst = 1'b1;
      #1 chk("rst_async", {upd_if.upd_ready, y, w}, {1'b1, 1'b0, 4'h0});
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1 chk("rst_x_c0", x, 1'b0);
      @(posedge clk);
      #2;
      #1 chk("rst_x_c1", x, 1'b0);
      @(posedge clk);
      #2;
      #1 chk("rst_x_c2", {x, w}, {1'b1, 4'h0});

      // d1 == 0: leading-zero suppression when enabled.
      goto(0);
      offer(1'b1, 4'h4, 4'h0);
      @(posedge clk);
      #2;
      offer(1'b0, 4'h0, 4'h0);
      goto(15);
`ifdef SCAN_CTRL_ZERO_BLANK_EN
      #1 chk("d1_zero_y", {y, w}, {1'b0, 4'h0});
`else
      #1 chk("d1_zero_y", {y, w}, {1'b1, 4'h0});
`endif
      goto(0);
      offer(1'b1, 4'h4, 4'hA);
      @(posedge clk);
      #2;
      offer(1'b0, 4'h0, 4'h0);
      goto(15);
      #1 chk("d1_a", {y, w}, {1'b1, 4'hA});

      repeat (30) @(posedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
